// File: rtl/score_fsm_if.sv
// rtl/score_fsm_if.sv - strobe inputs and score/status outputs of the match state machine
interface score_fsm_if;
   logic       timing_tick;
   logic       start_btn;
   logic       miss_left;
   logic       miss_right;
   logic [3:0] score_left;
   logic [3:0] score_right;
   logic       play_en;
   logic       game_over;
   logic       winner_left;
   logic       winner_right;
   logic [1:0] state;

   modport master (
      output timing_tick, start_btn, miss_left, miss_right,
      input  score_left, score_right, play_en, game_over,
      input  winner_left, winner_right, state
   );

   modport slave (
      input  timing_tick, start_btn, miss_left, miss_right,
      output score_left, score_right, play_en, game_over,
      output winner_left, winner_right, state
   );
endinterface

// File: rtl/score_fsm.sv
// rtl/score_fsm.sv - match state machine: scoring, post-point pause and game-over for pong
module score_fsm #(
   parameter int unsigned WIN_SCORE   = 11,
   parameter int unsigned PAUSE_TICKS = 60
) (
   input  logic          clk,
   input  logic          rst,
   score_fsm_if.slave    bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2,
      OVER  = 2'd3
   } state_t;

   localparam logic [3:0] WIN_Q   = 4'(WIN_SCORE);
   localparam logic [7:0] PAUSE_Q = 8'(PAUSE_TICKS);

   // bit 2 = start_btn, bit 1 = miss_left, bit 0 = miss_right
   logic [2:0] in_cur_q, in_cur_d;
   logic [2:0] in_prev_q, in_prev_d;
   logic [2:0] evt;

   state_t     state_q, state_d;
   logic [3:0] score_left_q, score_left_d;
   logic [3:0] score_right_q, score_right_d;
   logic [7:0] cnt_q, cnt_d;
   logic       play_en_q, play_en_d;
   logic       game_over_q, game_over_d;
   logic       winner_left_q, winner_left_d;
   logic       winner_right_q, winner_right_d;

   logic       start_evt, ml_evt, mr_evt;

   always_comb begin
      in_cur_d  = {bus.start_btn, bus.miss_left, bus.miss_right};
      in_prev_d = in_cur_q;
      evt       = in_cur_q & ~in_prev_q;
      start_evt = evt[2];
      ml_evt    = evt[1];
      mr_evt    = evt[0];
   end

   always_comb begin
      state_d       = state_q;
      score_left_d  = score_left_q;
      score_right_d = score_right_q;
      cnt_d         = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (start_evt) state_d = PLAY;
         end
         PLAY: begin
            if (ml_evt && mr_evt) begin
               state_d = PAUSE;
               cnt_d   = PAUSE_Q;
            end else if (ml_evt) begin
               if (score_right_q < WIN_Q) score_right_d = score_right_q + 4'd1;
               state_d = (score_right_d == WIN_Q) ? OVER : PAUSE;
               cnt_d   = PAUSE_Q;
            end else if (mr_evt) begin
               if (score_left_q < WIN_Q) score_left_d = score_left_q + 4'd1;
               state_d = (score_left_d == WIN_Q) ? OVER : PAUSE;
               cnt_d   = PAUSE_Q;
            end
         end
         PAUSE: begin
            if (bus.timing_tick) begin
               // a zero count can only come from a degenerate load; treat it as done
               if (cnt_q <= 8'd1) begin
                  cnt_d   = 8'd0;
                  state_d = PLAY;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         OVER: begin
            if (start_evt) begin
               score_left_d  = 4'd0;
               score_right_d = 4'd0;
               state_d       = PLAY;
            end
         end
         default: state_d = IDLE;
      endcase

      play_en_d      = (state_d == PLAY);
      game_over_d    = (state_d == OVER);
      winner_left_d  = (state_d == OVER) && (score_left_d == WIN_Q);
      winner_right_d = (state_d == OVER) && (score_right_d == WIN_Q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_cur_q       <= 3'b000;
         in_prev_q      <= 3'b000;
         state_q        <= IDLE;
         score_left_q   <= 4'd0;
         score_right_q  <= 4'd0;
         cnt_q          <= 8'd0;
         play_en_q      <= 1'b0;
         game_over_q    <= 1'b0;
         winner_left_q  <= 1'b0;
         winner_right_q <= 1'b0;
      end else begin
         in_cur_q       <= in_cur_d;
         in_prev_q      <= in_prev_d;
         state_q        <= state_d;
         score_left_q   <= score_left_d;
         score_right_q  <= score_right_d;
         cnt_q          <= cnt_d;
         play_en_q      <= play_en_d;
         game_over_q    <= game_over_d;
         winner_left_q  <= winner_left_d;
         winner_right_q <= winner_right_d;
      end
   end

   assign bus.state        = state_q;
   assign bus.score_left   = score_left_q;
   assign bus.score_right  = score_right_q;
   assign bus.play_en      = play_en_q;
   assign bus.game_over    = game_over_q;
   assign bus.winner_left  = winner_left_q;
   assign bus.winner_right = winner_right_q;
endmodule

// File: tb/tb_score_fsm.sv
// tb/tb_score_fsm.sv - directed bench for score_fsm with WIN_SCORE=3, PAUSE_TICKS=3
module tb_score_fsm;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   score_fsm_if bus ();

   score_fsm #(.WIN_SCORE(3), .PAUSE_TICKS(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      bus.timing_tick = 1'b1;
      step(1);
      bus.timing_tick = 1'b0;
   endtask

   task automatic finish_pause();
      for (int i = 0; i < 3; i++) begin
         tick();
         step(2);
      end
   endtask

   task automatic pulse_miss_right();
      bus.miss_right = 1'b1;
      step(1);
      bus.miss_right = 1'b0;
      step(1);
   endtask

   task automatic pulse_start();
      bus.start_btn = 1'b1;
      step(1);
      bus.start_btn = 1'b0;
      step(1);
   endtask

   initial begin
      bus.timing_tick = 1'b0;
      bus.start_btn   = 1'b0;
      bus.miss_left   = 1'b0;
      bus.miss_right  = 1'b0;
      step(2);
      check("rst_state", 8'(bus.state), 8'd0);
      check("rst_score_l", 8'(bus.score_left), 8'd0);
      check("rst_score_r", 8'(bus.score_right), 8'd0);
      check("rst_play_en", 8'(bus.play_en), 8'd0);
      check("rst_game_over", 8'(bus.game_over), 8'd0);
      check("rst_winners", 8'({bus.winner_left, bus.winner_right}), 8'd0);
      rst = 1'b0;
      step(2);

      // start: nothing after one clock, PLAY after two
      bus.start_btn = 1'b1;
      step(1);
      bus.start_btn = 1'b0;
      check("start_lat1_state", 8'(bus.state), 8'd0);
      step(1);
      check("start_state", 8'(bus.state), 8'd1);
      check("start_play_en", 8'(bus.play_en), 8'd1);
      check("start_scores", 8'({bus.score_left, bus.score_right}), 8'h00);

      // held miss_left counts once
      bus.miss_left = 1'b1;
      step(2);
      check("ml_score_r", 8'(bus.score_right), 8'd1);
      check("ml_state", 8'(bus.state), 8'd2);
      check("ml_play_en", 8'(bus.play_en), 8'd0);
      step(3);
      bus.miss_left = 1'b0;
      check("ml_held_score_r", 8'(bus.score_right), 8'd1);
      check("ml_held_score_l", 8'(bus.score_left), 8'd0);

      // pause: three ticks, miss_right toggled in between
      step(9);
      tick();
      step(2);
      bus.miss_right = 1'b1;
      step(1);
      bus.miss_right = 1'b0;
      step(6);
      tick();
      step(9);
      check("pause_before_last", 8'(bus.state), 8'd2);
      tick();
      check("pause_end_state", 8'(bus.state), 8'd1);
      check("pause_end_play_en", 8'(bus.play_en), 8'd1);
      check("pause_scores", 8'({bus.score_left, bus.score_right}), 8'h01);

      // both misses together
      step(2);
      bus.miss_left  = 1'b1;
      bus.miss_right = 1'b1;
      step(2);
      bus.miss_left  = 1'b0;
      bus.miss_right = 1'b0;
      check("both_scores", 8'({bus.score_left, bus.score_right}), 8'h01);
      check("both_state", 8'(bus.state), 8'd2);
      finish_pause();
      check("both_resume", 8'(bus.state), 8'd1);

      // three right misses win it for the left player
      pulse_miss_right();
      check("w1_score_l", 8'(bus.score_left), 8'd1);
      check("w1_state", 8'(bus.state), 8'd2);
      finish_pause();
      pulse_miss_right();
      check("w2_score_l", 8'(bus.score_left), 8'd2);
      finish_pause();
      check("w2_resume", 8'(bus.state), 8'd1);
      pulse_miss_right();
      check("win_score_l", 8'(bus.score_left), 8'd3);
      check("win_state", 8'(bus.state), 8'd3);
      check("win_game_over", 8'(bus.game_over), 8'd1);
      check("win_winner_l", 8'(bus.winner_left), 8'd1);
      check("win_winner_r", 8'(bus.winner_right), 8'd0);
      check("win_play_en", 8'(bus.play_en), 8'd0);
      pulse_miss_right();
      step(2);
      check("over_saturate", 8'(bus.score_left), 8'd3);
      check("over_hold_state", 8'(bus.state), 8'd3);

      // restart from OVER
      pulse_start();
      check("restart_scores", 8'({bus.score_left, bus.score_right}), 8'h00);
      check("restart_winners", 8'({bus.winner_left, bus.winner_right}), 8'd0);
      check("restart_game_over", 8'(bus.game_over), 8'd0);
      check("restart_state", 8'(bus.state), 8'd1);

      // async reset mid-pause
      bus.miss_left = 1'b1;
      step(2);
      bus.miss_left = 1'b0;
      check("pre_rst_state", 8'(bus.state), 8'd2);
      check("pre_rst_score_r", 8'(bus.score_right), 8'd1);
      step(3);
      #1 rst = 1'b1;
      #1;
      check("async_rst_state", 8'(bus.state), 8'd0);
      check("async_rst_play_en", 8'(bus.play_en), 8'd0);
      check("async_rst_scores", 8'({bus.score_left, bus.score_right}), 8'h00);
      step(2);
      rst = 1'b0;
      step(2);
      check("post_rst_idle", 8'(bus.state), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/score_fsm.md
Name: score_fsm

Overview:
- Sits directly downstream of the ball/paddle controller.
- Consumes its miss_left/miss_right strobes and keeps both players' scores.
- Runs the match state machine: idle, play, post-point pause, game over.
- Drives play_en, which freezes ball motion, plus scores and winner flags for the VGA overlay and score display.

Parameters:
- WIN_SCORE, 11, points needed to win the match (1..15).
- PAUSE_TICKS, 60, number of timing_tick pulses the ball stays frozen after a point (1..255).

Ports:
- clk  input  1  system clock (VGA pixel clock domain)
- rst  input  1  asynchronous, active-high reset
- timing_tick  input  1  one-clock frame-rate strobe, same as the one fed to the ball controller
- start_btn  input  1  start/restart request; already synchronized and debounced, level
- miss_left  input  1  left player missed; may stay high for more than one clock
- miss_right  input  1  right player missed; may stay high for more than one clock
- score_left  output  4  left player score, binary
- score_right  output  4  right player score, binary
- play_en  output  1  1 = ball may move; gates timing_tick into the ball controller
- game_over  output  1  1 while in GAME_OVER
- winner_left  output  1  left player won; valid while game_over
- winner_right  output  1  right player won; valid while game_over
- state  output  2  current state: 0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; scores=0; play_en=0; game_over=0; winners=0.
  - Pause counter=0; all edge-detect registers=0.
- Edge detection:
  - start_btn, miss_left and miss_right are each registered once.
  - An event is a rising edge, i.e. current=1 and previous=0. A held level counts once.
- Miss decoding:
  - A miss_left event gives a point to the right player.
  - A miss_right event gives a point to the left player.
- IDLE:
  - play_en=0; scores hold.
  - start event -> PLAY on the next clock.
- PLAY:
  - play_en=1.
  - Miss events in the same clock:
    - Exactly one miss event: the scorer's score increments in that clock's update, registered 1 cycle after the edge is detected.
    - If the new score equals WIN_SCORE -> OVER; otherwise -> PAUSE with the counter loaded to PAUSE_TICKS.
    - Both miss events together: no score change; -> PAUSE.
  - Start events are ignored.
- PAUSE:
  - play_en=0.
  - Each timing_tick decrements the counter.
  - The tick that takes the counter from 1 to 0 moves to PLAY on the next clock.
  - Miss and start events are ignored.
- OVER:
  - play_en=0; game_over=1.
  - winner_left=(score_left==WIN_SCORE); winner_right=(score_right==WIN_SCORE). At most one can be set.
  - A start event clears both scores and the winner flags, and goes to PLAY in one clock.
- Arithmetic and outputs:
  - Scores saturate at WIN_SCORE and never wrap.
  - All outputs are registered. No output depends combinationally on an input.
- Latency:
  - Input pin to detected edge: 1 clock.
  - Edge to state, score and play_en update: 1 clock.
  - Total: 2 clocks from input pin to output.
- Reset mid-operation returns to IDLE immediately, with scores cleared.
- timing_tick is used only in PAUSE.

Test Plan:
1. Reset, then a start_btn pulse -> state=1 and play_en=1 two clocks after the pulse; scores 0/0.
2. In PLAY, raise miss_left and hold it for 5 clocks -> score_right=1 exactly once, score_left=0; state=2; play_en=0.
3. In PAUSE with PAUSE_TICKS=3, apply 3 timing_ticks spaced 10 clocks apart -> state=1 one clock after the third tick. Also toggle miss_right during the pause -> no score change.
4. With WIN_SCORE=3, give three miss_right events, each separated by a completed pause -> score_left=3, state=3, game_over=1, winner_left=1, winner_right=0.
5. miss_left and miss_right rising on the same clock in PLAY -> scores unchanged; state=2.
6. From OVER, apply start_btn -> scores 0/0, winners 0, state=1. Assert rst while in PAUSE -> immediately state=0, play_en=0, scores 0.
